reg_file_wb_ctrl: RTL and testbench
===================================

Name: reg_file_wb_ctrl

Overview:
Writeback controller that drives the register file's single write port (reg_write/waddr/wdata). It merges single-cycle ALU results with variable-latency load responses and buffers load responses in a small FIFO. A 32-entry pending-load scoreboard raises a hazard to decode when a source or destination register awaits load data.

Parameters:
LQ_DEPTH, 4, load-response FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, cycles the FIFO head may wait before stall_req asserts

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
alu_valid  input  1  ALU result valid this cycle, never back-pressured
alu_rd  input  5  ALU destination register
alu_result  input  32  ALU result
ld_issue  input  1  load issued this cycle
ld_issue_rd  input  5  destination of the issued load
ld_resp_valid  input  1  load response valid
ld_resp_ready  output  1  FIFO can accept a response
ld_resp_rd  input  5  load response destination
ld_resp_data  input  32  load response data
id_rs1  input  5  decode source 1
id_rs2  input  5  decode source 2
id_rd  input  5  decode destination
hazard  output  1  decode must stall
stall_req  output  1  request upstream to hold alu_valid low
reg_write  output  1  register file write enable
waddr  output  5  register file write address
wdata  output  32  register file write data
lq_count  output  $clog2(LQ_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, reset_n low):
  - reg_write=0, waddr=0, wdata=0, stall_req=0, lq_count=0.
  - Scoreboard cleared, FIFO pointers 0, age counter 0.
  - Reset mid-operation discards all buffered responses.
- ld_resp_ready = (lq_count < LQ_DEPTH), combinational from registered count.
  - Response accepted when ld_resp_valid && ld_resp_ready.
  - A response is accepted even when the FIFO is full if a pop occurs that same cycle? No: ready depends only on registered count.
- Write-port arbitration, evaluated each cycle:
  - alu_valid=1: ALU wins. Next edge: reg_write=1, waddr=alu_rd, wdata=alu_result.
  - else if FIFO non-empty: pop head. Next edge: reg_write=1, waddr/wdata from head.
  - else: reg_write=0; waddr/wdata hold their last values.
- Output latency: 1 cycle, registered. FIFO path: a response accepted at edge N is written to the register file at edge N+1 at the earliest. Bypass of an empty FIFO is not allowed.
- x0 handling:
  - Any source with rd=0 produces reg_write=0 for that slot.
  - A FIFO entry with rd=0 is still popped.
  - ld_issue with rd=0 does not set the scoreboard.
- Scoreboard pending[31:0]:
  - Set at the edge after ld_issue (rd!=0).
  - Cleared at the edge when the load entry for that rd is popped to the write port.
  - Set and clear for the same rd in the same cycle: set wins.
  - pending[0] is always 0.
- hazard is combinational: pending[id_rs1] | pending[id_rs2] | pending[id_rd], each term gated by the register index being nonzero.
- Starvation:
  - Age counter increments each cycle the FIFO is non-empty and the head is not popped.
  - Counter resets to 0 on any pop or when the FIFO is empty.
  - stall_req registered, asserted when age >= STARVE_LIMIT-1 at the edge; deasserted at the edge after the head pops.
  - If alu_valid arrives while stall_req=1, ALU still wins. No error is flagged.
- FIFO push and pop in the same cycle: count unchanged, pointers wrap modulo LQ_DEPTH.
- A push to a full FIFO cannot occur, because ready=0.

Test Plan:
1. Reset then idle → reg_write=0, waddr=0, wdata=0, lq_count=0, ld_resp_ready=1, hazard=0.
2. alu_valid=1, rd=5, result=0xDEADBEEF → next edge reg_write=1, waddr=5, wdata=0xDEADBEEF. Same stimulus with rd=0 → reg_write=0.
3. ld_issue rd=7; then id_rs2=7 → hazard=1. Response rd=7, data=0x12345678 with no ALU traffic → accepted at N, write at N+1, hazard=0 after N+1. Same-cycle set and clear of rd=7 → stays pending.
4. Continuous alu_valid, 5 load responses pushed → ld_resp_ready=0 at lq_count=4, 5th response held. stall_req=1 after 8 cycles of head wait. Drop alu_valid → entries drain in FIFO order, 1 per cycle.
5. Push and pop in the same cycle at lq_count=2 → count stays 2. Pointer wrap after 6 pushes → data order preserved.
6. Assert reset_n low with 3 entries queued and pending[9]=1 → immediately lq_count=0, reg_write=0, hazard for rs1=9 is 0.

Source files
------------

// File: rtl/reg_file_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reg_file_wb_ctrl                                           |
// | Description : Register-file writeback arbiter (ALU over load FIFO) with  |
// |               a pending-load scoreboard and head-starvation stall.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module reg_file_wb_ctrl #(
   parameter int LQ_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       alu_valid,
   input  logic [4:0]                 alu_rd,
   input  logic [31:0]                alu_result,
   input  logic                       ld_issue,
   input  logic [4:0]                 ld_issue_rd,
   input  logic                       ld_resp_valid,
   output logic                       ld_resp_ready,
   input  logic [4:0]                 ld_resp_rd,
   input  logic [31:0]                ld_resp_data,
   input  logic [4:0]                 id_rs1,
   input  logic [4:0]                 id_rs2,
   input  logic [4:0]                 id_rd,
   output logic                       hazard,
   output logic                       stall_req,
   output logic                       reg_write,
   output logic [4:0]                 waddr,
   output logic [31:0]                wdata,
   output logic [$clog2(LQ_DEPTH):0]  lq_count
);

   localparam int c_ptr_w = $clog2(LQ_DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam int c_age_w = $clog2(STARVE_LIMIT) + 1;
   localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(LQ_DEPTH);
   localparam logic [c_age_w-1:0] c_age_max = c_age_w'(STARVE_LIMIT - 1);

   logic [4:0]          rd_mem_q   [LQ_DEPTH];
   logic [4:0]          rd_mem_d   [LQ_DEPTH];
   logic [31:0]         data_mem_q [LQ_DEPTH];
   logic [31:0]         data_mem_d [LQ_DEPTH];
   logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_cnt_w-1:0]  count_q, count_d;
   logic [c_age_w-1:0]  age_q, age_d;
   logic                stall_q, stall_d;
   logic [31:0]         pending_q, pending_d;
   logic                reg_write_q, reg_write_d;
   logic [4:0]          waddr_q, waddr_d;
   logic [31:0]         wdata_q, wdata_d;

   logic                push;
   logic                pop;
   logic                fifo_empty;
   logic [4:0]          head_rd;
   logic [31:0]         head_data;

   // Ready looks only at the registered count, so a full FIFO refuses even on a pop cycle.
   assign ld_resp_ready = (count_q < c_depth);
   assign fifo_empty    = (count_q == '0);
   assign push          = ld_resp_valid && ld_resp_ready;
   assign pop           = !alu_valid && !fifo_empty;
   assign head_rd       = rd_mem_q[rd_ptr_q];
   assign head_data     = data_mem_q[rd_ptr_q];

   always_comb begin
      reg_write_d = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      if (alu_valid) begin
         reg_write_d = (alu_rd != 5'd0);
         waddr_d     = alu_rd;
         wdata_d     = alu_result;
      end else if (pop) begin
         reg_write_d = (head_rd != 5'd0);
         waddr_d     = head_rd;
         wdata_d     = head_data;
      end
   end

   always_comb begin
      rd_mem_d   = rd_mem_q;
      data_mem_d = data_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push) begin
         rd_mem_d[wr_ptr_q]   = ld_resp_rd;
         data_mem_d[wr_ptr_q] = ld_resp_data;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Clear first so a same-cycle issue to the popped register keeps it pending.
   always_comb begin
      pending_d = pending_q;
      if (pop && (head_rd != 5'd0)) begin
         pending_d[head_rd] = 1'b0;
      end
      if (ld_issue && (ld_issue_rd != 5'd0)) begin
         pending_d[ld_issue_rd] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   always_comb begin
      age_d   = age_q;
      stall_d = stall_q;
      if (fifo_empty || pop) begin
         age_d   = '0;
         stall_d = 1'b0;
      end else begin
         if (age_q < c_age_max) begin
            age_d = age_q + 1'b1;
         end
         if (age_q >= c_age_max) begin
            stall_d = 1'b1;
         end
      end
   end

   always_comb begin
      hazard = ((id_rs1 != 5'd0) && pending_q[id_rs1]) ||
               ((id_rs2 != 5'd0) && pending_q[id_rs2]) ||
               ((id_rd  != 5'd0) && pending_q[id_rd]);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_mem_q    <= '{default: '0};
         data_mem_q  <= '{default: '0};
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         age_q       <= '0;
         stall_q     <= 1'b0;
         pending_q   <= '0;
         reg_write_q <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         rd_mem_q    <= rd_mem_d;
         data_mem_q  <= data_mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         age_q       <= age_d;
         stall_q     <= stall_d;
         pending_q   <= pending_d;
         reg_write_q <= reg_write_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign reg_write = reg_write_q;
   assign waddr     = waddr_q;
   assign wdata     = wdata_q;
   assign stall_req = stall_q;
   assign lq_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_wb_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_reg_file_wb_ctrl                                        |
// | Description : Self-checking bench for reg_file_wb_ctrl (vector table,    |
// |               queue-based reference model, directed corner sequences).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_reg_file_wb_ctrl;

   localparam int LQ_DEPTH     = 4;
   localparam int STARVE_LIMIT = 8;
   localparam int CW           = $clog2(LQ_DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          alu_valid = 1'b0;
   logic [4:0]    alu_rd = '0;
   logic [31:0]   alu_result = '0;
   logic          ld_issue = 1'b0;
   logic [4:0]    ld_issue_rd = '0;
   logic          ld_resp_valid = 1'b0;
   logic          ld_resp_ready;
   logic [4:0]    ld_resp_rd = '0;
   logic [31:0]   ld_resp_data = '0;
   logic [4:0]    id_rs1 = '0;
   logic [4:0]    id_rs2 = '0;
   logic [4:0]    id_rd = '0;
   logic          hazard;
   logic          stall_req;
   logic          reg_write;
   logic [4:0]    waddr;
   logic [31:0]   wdata;
   logic [CW-1:0] lq_count;

   always #5 clk = ~clk;

   reg_file_wb_ctrl #(.LQ_DEPTH(LQ_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result),
      .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
      .ld_resp_valid(ld_resp_valid), .ld_resp_ready(ld_resp_ready),
      .ld_resp_rd(ld_resp_rd), .ld_resp_data(ld_resp_data),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .hazard(hazard), .stall_req(stall_req),
      .reg_write(reg_write), .waddr(waddr), .wdata(wdata),
      .lq_count(lq_count)
   );

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic          we;
      logic [4:0]    addr;
      logic [31:0]   data;
      logic [CW-1:0] cnt;
      logic          stall;
   } exp_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   typedef struct {
      logic        av;
      logic [4:0]  rd;
      logic [31:0] res;
      logic        exp_we;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
   } vec_t;

   exp_t        exp_q[$];
   ent_t        m_fifo[$];
   logic [31:0] m_pend = '0;
   int          m_age = 0;
   logic        m_stall = 1'b0;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic m_haz();
      return ((id_rs1 != 0) && m_pend[id_rs1]) ||
             ((id_rs2 != 0) && m_pend[id_rs2]) ||
             ((id_rd  != 0) && m_pend[id_rd]);
   endfunction

   task automatic model_reset();
      m_fifo.delete();
      exp_q.delete();
      m_pend  = '0;
      m_age   = 0;
      m_stall = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
   endtask

   // One clock: check combinational outputs, predict the next edge, tick, compare.
   task automatic cycle();
      exp_t e;
      ent_t h;
      int   sz;
      bit   pop;
      #1;
      sz = m_fifo.size();
      chk("ld_resp_ready", ld_resp_ready, (sz < LQ_DEPTH));
      chk("hazard", hazard, m_haz());
      pop  = !alu_valid && (sz != 0);
      e.we = 1'b0;
      h.rd = '0;
      if (alu_valid) begin
         e.we = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_result;
      end else if (pop) begin
         h = m_fifo.pop_front();
         e.we = (h.rd != 0); m_waddr = h.rd; m_wdata = h.data;
      end
      if (pop && h.rd != 0) m_pend[h.rd] = 1'b0;
      if (ld_issue && ld_issue_rd != 0) m_pend[ld_issue_rd] = 1'b1;
      if (pop || sz == 0) begin
         m_stall = 1'b0; m_age = 0;
      end else begin
         if (m_age >= STARVE_LIMIT - 1) m_stall = 1'b1;
         else m_age++;
      end
      if (ld_resp_valid && sz < LQ_DEPTH) m_fifo.push_back('{rd: ld_resp_rd, data: ld_resp_data});
      e.addr  = m_waddr;
      e.data  = m_wdata;
      e.cnt   = CW'(m_fifo.size());
      e.stall = m_stall;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("reg_write", reg_write, e.we);
      chk("waddr", waddr, e.addr);
      chk("wdata", wdata, e.data);
      chk("lq_count", lq_count, e.cnt);
      chk("stall_req", stall_req, e.stall);
   endtask

   vec_t vt[4];
   int   k;
   bit   acc;

   initial begin
      // ---- 1: reset then idle
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      chk("rst_reg_write", reg_write, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_lq_count", lq_count, 0);
      chk("rst_ready", ld_resp_ready, 1);
      chk("rst_hazard", hazard, 0);
      cycle();

      // ---- 2: ALU path vectors
      vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'hDEADBEEF};
      vt[1] = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  32'hDEADBEEF};
      vt[2] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd31, 32'h00000001};
      vt[3] = '{1'b0, 5'd3,  32'h0000FFFF, 1'b0, 5'd31, 32'h00000001};
      for (int i = 0; i < 4; i++) begin
         alu_valid = vt[i].av; alu_rd = vt[i].rd; alu_result = vt[i].res;
         cycle();
         chk("vec_we", reg_write, vt[i].exp_we);
         chk("vec_addr", waddr, vt[i].exp_addr);
         chk("vec_data", wdata, vt[i].exp_data);
      end
      alu_valid = 1'b0;

      // ---- 3: scoreboard and load path latency
      ld_issue = 1'b1; ld_issue_rd = 5'd7;
      cycle();
      ld_issue = 1'b0; id_rs2 = 5'd7;
      #1 chk("haz_pending7", hazard, 1);
      ld_resp_valid = 1'b1; ld_resp_rd = 5'd7; ld_resp_data = 32'h12345678;
      cycle();
      ld_resp_valid = 1'b0;
      chk("ld_accept_cnt", lq_count, 1);
      chk("ld_no_bypass", reg_write, 0);
      cycle();
      chk("ld_write_we", reg_write, 1);
      chk("ld_write_addr", waddr, 7);
      chk("ld_write_data", wdata, 32'h12345678);
      #1 chk("haz_cleared7", hazard, 0);
      ld_issue = 1'b1;
      cycle();
      ld_issue = 1'b0; ld_resp_valid = 1'b1;
      cycle();
      ld_resp_valid = 1'b0; ld_issue = 1'b1;
      cycle();
      ld_issue = 1'b0;
      #1 chk("haz_set_wins", hazard, 1);
      ld_resp_valid = 1'b1; ld_resp_data = 32'h0BADF00D;
      cycle();
      ld_resp_valid = 1'b0;
      cycle();
      #1 chk("haz_final_clear", hazard, 0);
      id_rs2 = 5'd0;

      // ---- 4: back-pressure, starvation, in-order drain
      alu_valid = 1'b1; ld_resp_valid = 1'b1; k = 0;
      for (int i = 0; i < 12; i++) begin
         alu_rd = 5'(i + 1); alu_result = 32'hC0DE_0000 + i;
         ld_resp_rd = 5'(10 + k); ld_resp_data = 32'hA000_0000 + k;
         #1 acc = ld_resp_ready;
         cycle();
         if (acc) k++;
         if (i == 3) begin
            chk("full_cnt", lq_count, 4);
            #1 chk("full_ready", ld_resp_ready, 0);
         end
         if (i == 7) chk("stall_before_limit", stall_req, 0);
         if (i == 8) chk("stall_at_limit", stall_req, 1);
      end
      chk("fifth_held", k, 4);
      alu_valid = 1'b0;
      for (int d = 0; d < 5; d++) begin
         ld_resp_valid = (k < 5);
         ld_resp_rd = 5'(10 + k); ld_resp_data = 32'hA000_0000 + k;
         #1 acc = ld_resp_ready && ld_resp_valid;
         cycle();
         if (acc) k++;
         chk("drain_we", reg_write, 1);
         chk("drain_order", waddr, 10 + d);
         if (d == 0) chk("stall_released", stall_req, 0);
      end
      ld_resp_valid = 1'b0;

      // ---- 5: simultaneous push/pop and pointer wrap
      for (int i = 0; i < 8; i++) begin
         alu_valid = (i < 2); alu_rd = 5'd2; alu_result = 32'h5;
         ld_resp_valid = (i < 6); ld_resp_rd = 5'(20 + i); ld_resp_data = 32'hB000_0000 + i;
         cycle();
         if (i >= 2) chk("wrap_order", waddr, 20 + i - 2);
         if (i >= 2 && i < 6) chk("pushpop_cnt", lq_count, 2);
      end
      alu_valid = 1'b0; ld_resp_valid = 1'b0;

      // ---- 6: async reset mid-operation
      ld_issue = 1'b1; ld_issue_rd = 5'd9;
      cycle();
      ld_issue = 1'b0; alu_valid = 1'b1; alu_rd = 5'd4; ld_resp_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ld_resp_rd = 5'(1 + i); ld_resp_data = 32'hE000_0000 + i;
         cycle();
      end
      ld_resp_valid = 1'b0;
      id_rs1 = 5'd9;
      #1 chk("pre_rst_haz9", hazard, 1);
      chk("pre_rst_cnt", lq_count, 3);
      reset_n = 1'b0;
      #1;
      chk("async_rst_cnt", lq_count, 0);
      chk("async_rst_we", reg_write, 0);
      chk("async_rst_haz9", hazard, 0);
      chk("async_rst_ready", ld_resp_ready, 1);
      alu_valid = 1'b0;
      model_reset();
      @(posedge clk);
      #1 reset_n = 1'b1;
      cycle();
      cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
